// File: rtl/mu_acc_pkg.sv
// mu_acc_pkg
//   Shared constants for the mu-cost accumulator.
//   - ST_IDLE / ST_ISSUE / ST_HALT : sequencer state encodings
//   - MU_SAT          : all-ones pattern, sliced to the datapath width by users
//   - MU_BUDGET_RESET : budget value after reset (all-ones, so no budget limit)
//   MU_SAT and MU_BUDGET_RESET are 64 bits wide. Users slice them to W, so any
//   datapath width W <= 64 is supported.
package mu_acc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [63:0] MU_SAT          = '1;
  localparam logic [63:0] MU_BUDGET_RESET = MU_SAT;

endpackage

// File: rtl/mu_cost_accumulator.sv
// mu_cost_accumulator
//   Sequencer and ledger around the external combinational mu-ALU adder.
//   A delta is accepted through a valid/ready handshake. The block presents
//   (running total, delta) to the ALU and waits for alu_ready. It then commits
//   the sum to the ledger, saturating at all-ones on wrap-around, and halts when
//   the ledger exceeds the programmed budget.
//
//   Handshake: a delta is transferred on a rising edge where in_valid and
//   in_ready are both 1. in_ready does not depend on in_valid. The producer
//   holds in_delta stable while in_valid is 1.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     clear                 synchronous clear of ledger, flags and FSM (highest priority)
//     in_valid/in_ready     delta handshake
//     in_delta [W]          unsigned mu-cost increment
//     budget_load/budget_in budget register write (any state)
//     alu_operand_a/b [W]   to mu-ALU: total, captured delta (0 outside ISSUE)
//     alu_result [W]        from mu-ALU: a + b mod 2^W
//     alu_ready             from mu-ALU: result valid this cycle
//     mu_total [W]          committed ledger
//     commit_valid          one-cycle pulse after each commit
//     overflow              sticky: a commit wrapped
//     budget_halt           sticky: ledger exceeded budget
//     commit_count [CNT_W]  commit counter (0 unless MU_ACC_STATS_EN is defined)
//     state_dbg [2]         current sequencer state (mu_acc_pkg encodings)
//
//   Build option: define MU_ACC_STATS_EN to build the saturating commit counter.
//   When the macro is not defined, commit_count is tied to 0.
module mu_cost_accumulator
  import mu_acc_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_delta,
  input  logic             budget_load,
  input  logic [W-1:0]     budget_in,
  output logic [W-1:0]     alu_operand_a,
  output logic [W-1:0]     alu_operand_b,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_ready,
  output logic [W-1:0]     mu_total,
  output logic             commit_valid,
  output logic             overflow,
  output logic             budget_halt,
  output logic [CNT_W-1:0] commit_count,
  output logic [1:0]       state_dbg
);

  localparam logic [W-1:0] SAT       = MU_SAT[W-1:0];
  localparam logic [W-1:0] BUDGET_RV = MU_BUDGET_RESET[W-1:0];

  logic [1:0]   state_q;
  logic [W-1:0] total_q;
  logic [W-1:0] delta_q;
  logic [W-1:0] budget_q;
  logic         commit_valid_q;
  logic         overflow_q;
  logic         halt_q;

  logic         accept;
  logic         commit;
  logic         ovf;
  logic [W-1:0] next_total;

  // in_ready is low during reset and during the clear cycle, even in IDLE.
  assign in_ready = rst_n && !clear && (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign commit   = (state_q == ST_ISSUE) && alu_ready;

  // The sum wrapped if and only if it is smaller than the old total.
  assign ovf        = (alu_result < total_q);
  assign next_total = ovf ? SAT : alu_result;

  assign alu_operand_a = total_q;
  assign alu_operand_b = (state_q == ST_ISSUE) ? delta_q : '0;

  assign mu_total     = total_q;
  assign commit_valid = commit_valid_q;
  assign overflow     = overflow_q;
  assign budget_halt  = halt_q;
  assign state_dbg    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      total_q        <= '0;
      delta_q        <= '0;
      commit_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      halt_q         <= 1'b0;
    end else if (clear) begin
      state_q        <= ST_IDLE;
      total_q        <= '0;
      delta_q        <= '0;
      commit_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      halt_q         <= 1'b0;
    end else begin
      commit_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            delta_q <= in_delta;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (commit) begin
            total_q        <= next_total;
            commit_valid_q <= 1'b1;
            overflow_q     <= overflow_q | ovf;
            // Compare against budget_q as it was before this edge. A budget
            // load in the same cycle only affects later commits.
            if (next_total > budget_q) begin
              halt_q  <= 1'b1;
              state_q <= ST_HALT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The budget is written in any state. It keeps its value through clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      budget_q <= BUDGET_RV;
    end else if (budget_load) begin
      budget_q <= budget_in;
    end
  end

`ifdef MU_ACC_STATS_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (commit && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign commit_count = count_q;
`else
  assign commit_count = '0;
`endif

endmodule
